gear: RTL and testbench
=======================

Name: gear

Overview:
- Registered 4-bit-speed to 2-bit-gear selector.
- Maps an unsigned speed/load code `in` (0..15) to a gear index `out` (0..3) using three upshift thresholds and a downshift hysteresis band.
- Moves at most one gear per clock.
- Sits between the speed-sensing front end and the drive/ratio control logic; `out` is a clean, glitch-free registered gear number.

Parameters:
- UP_T1, default 4: speed at or above which gear 0 upshifts to gear 1.
- UP_T2, default 8: speed at or above which gear 1 upshifts to gear 2.
- UP_T3, default 12: speed at or above which gear 2 upshifts to gear 3.
- HYST, default 0: downshift hysteresis. Gear g (g>=1) downshifts when in < UP_Tg - HYST.
- Legal set: 1 <= UP_T1 < UP_T2 < UP_T3 <= 15 and HYST < UP_T1. Other values are illegal; elaboration fails via a generate-time check.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in  input  4  unsigned speed code, sampled on rising clk
- out  output  2  current gear, registered
- shift  output  1  one-cycle pulse, high in the cycle after `out` changed
- dir  output  1  direction of the last shift: 1 = up, 0 = down; registered, holds between shifts

Behaviour:
- Reset (rst=1, asynchronous, immediate, overrides clk): out=0, shift=0, dir=0. All state returns to gear 0 even mid-operation. First update is on the first rising clk after rst deasserts.
- Per rising clk, current gear g = out:
  - Upshift when g<3 and in >= UP_T(g+1): out <= g+1.
  - Else downshift when g>0 and in < UP_Tg - HYST: out <= g-1.
  - Else hold.
- At most one step per clock; a large speed jump walks through the gears one per cycle.
- Up and down conditions are mutually exclusive for legal parameters; upshift is evaluated first.
- Saturation:
  - gear 3 never upshifts, even at in=15;
  - gear 0 never downshifts, even at in=0;
  - no wrap-around.
- Latency: out reflects in one cycle after in crosses a threshold.
- shift: high for exactly one cycle after any out change, else 0.
- dir: updates together with out on each shift; unchanged on hold.
- Default mapping with HYST=0 in steady state equals in[3:2]. Ramp 0..15 at one step/clock yields out 0,0,0,0,0,1,1,1,1,2,… (one cycle lag).
- No combinational path from in to any output.

Decomposition:
- Shared package gear_pkg holds:
  - typedef gear_t (2-bit unsigned);
  - constants GEAR_MIN=0, GEAR_MAX=3;
  - default threshold constants.
- One natural sub-module, gear_threshold_cmp: combinational. Given g and in, it produces up_req/dn_req.
- The top level holds the state register, shift/dir registers and the parameter legality check.

Test Plan:
- Reset: assert rst asynchronously between clk edges while out=3 -> out=0, shift=0, dir=0 immediately, without a clk edge.
- Ascending ramp: in 0..15, one step per clk, HYST=0 -> out steps 0->1->2->3 one cycle after in=4, 8, 12. shift pulses 3 times with dir=1; out holds 3 at in=15.
- Descending ramp: in 15..0 with HYST=1 -> downshifts one cycle after in=10 (3->2), 6 (2->1), 2 (1->0). shift pulses 3 times with dir=0.
- Step jump: from out=0, in=15 held -> out 1, 2, 3 on three consecutive clks; shift high for 3 cycles; then out stays 3 and shift=0.
- Hysteresis hold: HYST=1, out=2, in toggling 7/8 -> out stays 2 (7 is not < 7); shift never pulses.
- Saturation: out=0 with in=0 for 5 clks -> out=0, shift=0. out=3 with in=15 -> out=3, shift=0.

Source files
------------

// File: rtl/gear_pkg.sv
// Shared types and defaults for the speed-to-gear selector.
package gear_pkg;

   typedef logic [1:0] gear_t;

   localparam gear_t GEAR_MIN = 2'd0;
   localparam gear_t GEAR_MAX = 2'd3;

   localparam int UP_T1_DEF = 4;
   localparam int UP_T2_DEF = 8;
   localparam int UP_T3_DEF = 12;
   localparam int HYST_DEF  = 0;

endpackage

// File: rtl/gear_threshold_cmp.sv
// Combinational shift-request logic: compares speed against the thresholds
// that bracket the current gear.
module gear_threshold_cmp
   import gear_pkg::*;
#(
   parameter int UP_T1 = UP_T1_DEF,
   parameter int UP_T2 = UP_T2_DEF,
   parameter int UP_T3 = UP_T3_DEF,
   parameter int HYST  = HYST_DEF
) (
   input  gear_t      i_gear,
   input  logic [3:0] i_speed,
   output logic       o_up_req,
   output logic       o_dn_req
);

   // Five bits so the downshift limits never wrap when compared against speed.
   localparam logic [4:0] L_UP1 = 5'(UP_T1);
   localparam logic [4:0] L_UP2 = 5'(UP_T2);
   localparam logic [4:0] L_UP3 = 5'(UP_T3);
   localparam logic [4:0] L_DN1 = 5'(UP_T1 - HYST);
   localparam logic [4:0] L_DN2 = 5'(UP_T2 - HYST);
   localparam logic [4:0] L_DN3 = 5'(UP_T3 - HYST);

   logic [4:0] w_speed;
   assign w_speed = {1'b0, i_speed};

   always_comb begin
      o_up_req = 1'b0;
      o_dn_req = 1'b0;
      case (i_gear)
         2'd0: begin
            o_up_req = (w_speed >= L_UP1);
         end
         2'd1: begin
            o_up_req = (w_speed >= L_UP2);
            o_dn_req = (w_speed <  L_DN1);
         end
         2'd2: begin
            o_up_req = (w_speed >= L_UP3);
            o_dn_req = (w_speed <  L_DN2);
         end
         default: begin
            o_dn_req = (w_speed <  L_DN3);
         end
      endcase
   end

endmodule

// File: rtl/gear.sv
// Registered speed-to-gear selector: one gear step per clock with a
// downshift hysteresis band, plus shift pulse and direction flag.
module gear
   import gear_pkg::*;
#(
   parameter int UP_T1 = UP_T1_DEF,
   parameter int UP_T2 = UP_T2_DEF,
   parameter int UP_T3 = UP_T3_DEF,
   parameter int HYST  = HYST_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] in,
   output logic [1:0] out,
   output logic       shift,
   output logic       dir
);

   if (!(UP_T1 >= 1 && UP_T1 < UP_T2 && UP_T2 < UP_T3 && UP_T3 <= 15 &&
         HYST >= 0 && HYST < UP_T1)) begin : g_bad_params
      $error("gear: illegal threshold/hysteresis parameters");
   end

   gear_t r_gear;
   logic  r_shift;
   logic  r_dir;
   logic  w_up_req;
   logic  w_dn_req;

   gear_threshold_cmp #(
      .UP_T1 (UP_T1),
      .UP_T2 (UP_T2),
      .UP_T3 (UP_T3),
      .HYST  (HYST)
   ) u_cmp (
      .i_gear   (r_gear),
      .i_speed  (in),
      .o_up_req (w_up_req),
      .o_dn_req (w_dn_req)
   );

   // Saturation at GEAR_MIN/GEAR_MAX is handled by the comparator never
   // requesting a step past either end.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_gear  <= GEAR_MIN;
         r_shift <= 1'b0;
         r_dir   <= 1'b0;
      end else begin
         r_shift <= w_up_req | w_dn_req;
         if (w_up_req) begin
            r_gear <= r_gear + 2'd1;
            r_dir  <= 1'b1;
         end else if (w_dn_req) begin
            r_gear <= r_gear - 2'd1;
            r_dir  <= 1'b0;
         end
      end
   end

   assign out   = r_gear;
   assign shift = r_shift;
   assign dir   = r_dir;

endmodule

// File: tb/tb_gear.sv
// Directed bench for gear: one DUT with HYST=0, one with HYST=1.
module tb_gear;

   logic       clk;
   logic       rst0, rst1;
   logic [3:0] in0, in1;
   logic [1:0] out0, out1;
   logic       shift0, shift1;
   logic       dir0, dir1;

   int n_cmp = 0;
   int n_err = 0;

   gear #(.UP_T1(4), .UP_T2(8), .UP_T3(12), .HYST(0)) u_h0 (
      .clk(clk), .rst(rst0), .in(in0), .out(out0), .shift(shift0), .dir(dir0)
   );

   gear #(.UP_T1(4), .UP_T2(8), .UP_T3(12), .HYST(1)) u_h1 (
      .clk(clk), .rst(rst1), .in(in1), .out(out1), .shift(shift1), .dir(dir1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst0 = 1'b1; rst1 = 1'b1; in0 = 4'd15; in1 = 4'd15;
      tick(); tick();
      n_cmp++;
      if ({out0, shift0, dir0} !== 4'b0000) begin
         $display("FAIL reset_h0 got out=%0d shift=%0b dir=%0b want 0/0/0", out0, shift0, dir0);
         n_err++;
      end
      n_cmp++;
      if ({out1, shift1, dir1} !== 4'b0000) begin
         $display("FAIL reset_h1 got out=%0d shift=%0b dir=%0b want 0/0/0", out1, shift1, dir1);
         n_err++;
      end
      in0 = 4'd0; in1 = 4'd0;
      rst0 = 1'b0; rst1 = 1'b0;
   endtask

   // Out after the edge that sampled in=v.
   task automatic test_ramp_up();
      logic [1:0] exp_out [16] = '{0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3};
      logic [15:0] exp_shift = 16'b0001_0001_0001_0000;
      int pulses = 0;
      for (int v = 0; v < 16; v++) begin
         in0 = 4'(v);
         tick();
         if (shift0 === 1'b1) pulses++;
         n_cmp++;
         if (out0 !== exp_out[v] || shift0 !== exp_shift[v] || dir0 !== (v >= 4)) begin
            $display("FAIL ramp_up in=%0d got out=%0d shift=%0b dir=%0b want %0d/%0b/%0b",
                     v, out0, shift0, dir0, exp_out[v], exp_shift[v], (v >= 4));
            n_err++;
         end
      end
      n_cmp++;
      if (pulses != 3) begin
         $display("FAIL ramp_up_pulses got %0d want 3", pulses);
         n_err++;
      end
   endtask

   task automatic test_step_jump();
      logic [1:0] exp_out [5] = '{1,2,3,3,3};
      logic [4:0] exp_shift = 5'b00111;
      in1 = 4'd15;
      for (int k = 0; k < 5; k++) begin
         tick();
         n_cmp++;
         if (out1 !== exp_out[k] || shift1 !== exp_shift[k] || dir1 !== 1'b1) begin
            $display("FAIL step_jump k=%0d got out=%0d shift=%0b dir=%0b want %0d/%0b/1",
                     k, out1, shift1, dir1, exp_out[k], exp_shift[k]);
            n_err++;
         end
      end
   endtask

   task automatic test_ramp_down();
      logic [1:0] exp_out [16] = '{0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,3};
      logic [15:0] exp_shift = 16'b0000_0100_0100_0100;
      int pulses = 0;
      logic exp_dir;
      for (int v = 15; v >= 0; v--) begin
         in1 = 4'(v);
         tick();
         exp_dir = (v >= 11);
         if (shift1 === 1'b1) pulses++;
         n_cmp++;
         if (out1 !== exp_out[v] || shift1 !== exp_shift[v] || dir1 !== exp_dir) begin
            $display("FAIL ramp_down in=%0d got out=%0d shift=%0b dir=%0b want %0d/%0b/%0b",
                     v, out1, shift1, dir1, exp_out[v], exp_shift[v], exp_dir);
            n_err++;
         end
      end
      n_cmp++;
      if (pulses != 3) begin
         $display("FAIL ramp_down_pulses got %0d want 3", pulses);
         n_err++;
      end
   endtask

   task automatic test_hysteresis();
      in1 = 4'd8;
      tick(); tick();
      n_cmp++;
      if (out1 !== 2'd2) begin
         $display("FAIL hyst_setup got out=%0d want 2", out1);
         n_err++;
      end
      for (int k = 0; k < 8; k++) begin
         in1 = (k % 2 == 0) ? 4'd7 : 4'd8;
         tick();
         n_cmp++;
         if (out1 !== 2'd2 || shift1 !== 1'b0) begin
            $display("FAIL hyst_hold in=%0d got out=%0d shift=%0b want 2/0", in1, out1, shift1);
            n_err++;
         end
      end
      in1 = 4'd6;
      tick();
      n_cmp++;
      if (out1 !== 2'd1 || shift1 !== 1'b1 || dir1 !== 1'b0) begin
         $display("FAIL hyst_exit got out=%0d shift=%0b dir=%0b want 1/1/0", out1, shift1, dir1);
         n_err++;
      end
   endtask

   task automatic test_saturation();
      rst0 = 1'b1; tick(); rst0 = 1'b0;
      in0 = 4'd0;
      for (int k = 0; k < 5; k++) begin
         tick();
         n_cmp++;
         if (out0 !== 2'd0 || shift0 !== 1'b0) begin
            $display("FAIL sat_low k=%0d got out=%0d shift=%0b want 0/0", k, out0, shift0);
            n_err++;
         end
      end
      in0 = 4'd15;
      tick(); tick(); tick();
      for (int k = 0; k < 5; k++) begin
         tick();
         n_cmp++;
         if (out0 !== 2'd3 || shift0 !== 1'b0) begin
            $display("FAIL sat_high k=%0d got out=%0d shift=%0b want 3/0", k, out0, shift0);
            n_err++;
         end
      end
   endtask

   // Reset lands between edges, right after the shift into gear 3.
   task automatic test_async_reset();
      rst0 = 1'b1; tick(); rst0 = 1'b0;
      in0 = 4'd15;
      tick(); tick(); tick();
      n_cmp++;
      if (out0 !== 2'd3 || shift0 !== 1'b1 || dir0 !== 1'b1) begin
         $display("FAIL async_pre got out=%0d shift=%0b dir=%0b want 3/1/1", out0, shift0, dir0);
         n_err++;
      end
      #2 rst0 = 1'b1;
      #1;
      n_cmp++;
      if ({out0, shift0, dir0} !== 4'b0000) begin
         $display("FAIL async_reset got out=%0d shift=%0b dir=%0b want 0/0/0", out0, shift0, dir0);
         n_err++;
      end
      tick();
      rst0 = 1'b0;
      in0 = 4'd4;
      tick();
      n_cmp++;
      if (out0 !== 2'd1 || shift0 !== 1'b1 || dir0 !== 1'b1) begin
         $display("FAIL async_recover got out=%0d shift=%0b dir=%0b want 1/1/1", out0, shift0, dir0);
         n_err++;
      end
   endtask

   initial begin
      rst0 = 1'b1; rst1 = 1'b1; in0 = 4'd0; in1 = 4'd0;
      test_reset();
      test_ramp_up();
      test_step_jump();
      test_ramp_down();
      test_hysteresis();
      test_saturation();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
